mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller between an instruction-fetch port (IF)
// and a load/store port (MEM). One transaction is in flight at a time.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rdy                 global enable; low freezes all state and outputs
//   if_req_i/if_addr_i  word fetch request, held until if_ack_o
//   if_flush_i          discard the outstanding fetch (or block an IF grant in IDLE)
//   if_ack_o/if_data_o  one-cycle fetch completion and fetched word
//   mem_re_i/mem_we_i   load/store size (00 none, 01 byte, 10 half, 11 word), held until mem_ack_o
//   mem_rsign_i, mem_addr_i, mem_wdata_i   load sign-extend flag, address, store data
//   mem_ack_o/mem_rdata_o                  one-cycle load/store completion and load data
//   mc_*_o              command to the controller, valid for the single ISSUE cycle
//   mc_busy_i, mc_done_i, mc_data_i        controller status and read data
//
// Optional feature: define ARB_FAIRNESS_EN to let IF win after STARVE_LIMIT consecutive MEM
// grants taken while IF was waiting. Without it MEM always has priority.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic [1:0]  mem_re_i,
  input  logic [1:0]  mem_we_i,
  input  logic        mem_rsign_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic [1:0]  mc_re_o,
  output logic [1:0]  mc_we_o,
  output logic        mc_rsign_o,
  output logic [31:0] mc_addr_o,
  output logic [31:0] mc_wdata_o,
  input  logic        mc_busy_i,
  input  logic        mc_done_i,
  input  logic [31:0] mc_data_i
);

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be nonzero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic        owner_mem_q, owner_mem_d;  // 1: load/store owns the transaction, 0: fetch
  logic        is_store_q, is_store_d;
  logic        dropped_q, dropped_d;      // fetch flushed while in flight
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_data_q, if_data_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]  mc_re_q, mc_re_d;
  logic [1:0]  mc_we_q, mc_we_d;
  logic        mc_rsign_q, mc_rsign_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_wdata_q, mc_wdata_d;

  logic mem_pending, if_pending, force_if;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] starve_q, starve_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    is_store_d  = is_store_q;
    dropped_d   = dropped_q;
    if_ack_d    = if_ack_q;
    if_data_d   = if_data_q;
    mem_ack_d   = mem_ack_q;
    mem_rdata_d = mem_rdata_q;
    mc_re_d     = mc_re_q;
    mc_we_d     = mc_we_q;
    mc_rsign_d  = mc_rsign_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;

    mem_pending = (mem_re_i != 2'b00) || (mem_we_i != 2'b00);
    if_pending  = if_req_i && !if_flush_i;
`ifdef ARB_FAIRNESS_EN
    starve_d = starve_q;
    force_if = if_pending && (starve_q >= CntW'(STARVE_LIMIT));
`else
    force_if = 1'b0;
`endif

    if (rdy) begin
      if_ack_d  = 1'b0;
      mem_ack_d = 1'b0;
`ifdef ARB_FAIRNESS_EN
      if (!if_req_i) starve_d = '0;
`endif
      case (state_q)
        StIdle: begin
          // No grant in the ack cycle: the finished requester still holds its request and the
          // controller needs a cycle to drop done.
          if (!mc_busy_i && !if_ack_q && !mem_ack_q) begin
            if (mem_pending && !force_if) begin
              state_d     = StIssue;
              owner_mem_d = 1'b1;
              is_store_d  = (mem_we_i != 2'b00);
              dropped_d   = 1'b0;
              mc_we_d     = mem_we_i;
              mc_re_d     = (mem_we_i != 2'b00) ? 2'b00 : mem_re_i;
              mc_rsign_d  = mem_rsign_i;
              mc_addr_d   = mem_addr_i;
              mc_wdata_d  = mem_wdata_i;
`ifdef ARB_FAIRNESS_EN
              if (if_req_i && (starve_q < CntW'(STARVE_LIMIT))) starve_d = starve_q + CntW'(1);
`endif
            end else if (if_pending) begin
              state_d     = StIssue;
              owner_mem_d = 1'b0;
              is_store_d  = 1'b0;
              dropped_d   = 1'b0;
              mc_we_d     = 2'b00;
              mc_re_d     = 2'b11;
              mc_rsign_d  = 1'b0;
              mc_addr_d   = if_addr_i;
              mc_wdata_d  = 32'h0;
`ifdef ARB_FAIRNESS_EN
              starve_d = '0;
`endif
            end
          end
        end
        StIssue: begin
          state_d = StWait;
          mc_re_d = 2'b00;
          mc_we_d = 2'b00;
          if (!owner_mem_q && if_flush_i) dropped_d = 1'b1;
        end
        StWait: begin
          if (!owner_mem_q && if_flush_i) dropped_d = 1'b1;
          if (mc_done_i) begin
            state_d = StIdle;
            if (owner_mem_q) begin
              mem_ack_d = 1'b1;
              if (!is_store_q) mem_rdata_d = mc_data_i;
            end else if (!dropped_q && !if_flush_i) begin
              if_ack_d  = 1'b1;
              if_data_d = mc_data_i;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_mem_q <= 1'b0;
      is_store_q  <= 1'b0;
      dropped_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      if_data_q   <= 32'h0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= 32'h0;
      mc_re_q     <= 2'b00;
      mc_we_q     <= 2'b00;
      mc_rsign_q  <= 1'b0;
      mc_addr_q   <= 32'h0;
      mc_wdata_q  <= 32'h0;
`ifdef ARB_FAIRNESS_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      is_store_q  <= is_store_d;
      dropped_q   <= dropped_d;
      if_ack_q    <= if_ack_d;
      if_data_q   <= if_data_d;
      mem_ack_q   <= mem_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mc_re_q     <= mc_re_d;
      mc_we_q     <= mc_we_d;
      mc_rsign_q  <= mc_rsign_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
`ifdef ARB_FAIRNESS_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign mem_ack_o   = mem_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mc_re_o     = mc_re_q;
  assign mc_we_o     = mc_we_q;
  assign mc_rsign_o  = mc_rsign_q;
  assign mc_addr_o   = mc_addr_q;
  assign mc_wdata_o  = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. The bench plays both requesters and the
// memory controller; all stimulus changes and all sampling happen on falling clock edges.
// Optional: define ARB_FAIRNESS_EN (for both files) to also check the starvation rotation.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk, rst, rdy;
  logic        if_req_i, if_flush_i, if_ack_o;
  logic [31:0] if_addr_i, if_data_o;
  logic [1:0]  mem_re_i, mem_we_i, mc_re_o, mc_we_o;
  logic        mem_rsign_i, mem_ack_o, mc_rsign_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o, mc_addr_o, mc_wdata_o;
  logic        mc_busy_i, mc_done_i;
  logic [31:0] mc_data_i;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_rsign_i(mem_rsign_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .mc_re_o(mc_re_o), .mc_we_o(mc_we_o), .mc_rsign_o(mc_rsign_o),
    .mc_addr_o(mc_addr_o), .mc_wdata_o(mc_wdata_o),
    .mc_busy_i(mc_busy_i), .mc_done_i(mc_done_i), .mc_data_i(mc_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got still running, required finished");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_if_data = 32'h0;
  logic [31:0] exp_mem_rdata = 32'h0;

  typedef struct {
    bit          use_if, use_mem;
    logic [1:0]  re, we;
    logic        sign;
    logic [31:0] iaddr, maddr, wdata, rd_if, rd_mem;
    int          dly;
    logic [1:0]  exp_re, exp_we;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // One granted transaction, from ISSUE to the end of its ack pulse. Called at a falling edge
  // with the request already driven; the command must appear at the very next falling edge.
  task automatic serve(input string nm, input bit is_mem, input logic [1:0] ere,
                       input logic [1:0] ewe, input logic esign, input logic [31:0] eaddr,
                       input logic [31:0] ewdata, input logic [31:0] rd, input int dly,
                       input bit flush);
    int n;
    @(negedge clk);
    n = 0;
    while (mc_re_o == 2'b00 && mc_we_o == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".issue_wait"}, n, 0);
    chk({nm, ".mc_re"}, mc_re_o, ere);
    chk({nm, ".mc_we"}, mc_we_o, ewe);
    chk({nm, ".mc_rsign"}, mc_rsign_o, esign);
    chk({nm, ".mc_addr"}, mc_addr_o, eaddr);
    chk({nm, ".mc_wdata"}, mc_wdata_o, ewdata);
    @(negedge clk);
    chk({nm, ".issue_one_cycle"}, {mc_re_o, mc_we_o}, 0);
    chk({nm, ".addr_hold"}, mc_addr_o, eaddr);
    chk({nm, ".wdata_hold"}, mc_wdata_o, ewdata);
    if (flush) begin
      if_flush_i = 1'b1;
      if_req_i   = 1'b0;
      @(negedge clk);
      if_flush_i = 1'b0;
    end
    repeat (dly) @(negedge clk);
    chk({nm, ".no_early_ack"}, {if_ack_o, mem_ack_o}, 0);
    mc_done_i = 1'b1;
    mc_data_i = rd;
    @(negedge clk);
    mc_done_i = 1'b0;
    mc_data_i = ~rd;
    if (is_mem) begin
      if (ewe == 2'b00) exp_mem_rdata = rd;
      chk({nm, ".mem_ack"}, mem_ack_o, 1);
      chk({nm, ".if_ack_quiet"}, if_ack_o, 0);
      chk({nm, ".mem_rdata"}, mem_rdata_o, exp_mem_rdata);
      mem_re_i = 2'b00;
      mem_we_i = 2'b00;
    end else begin
      if (!flush) exp_if_data = rd;
      chk({nm, ".if_ack"}, if_ack_o, flush ? 0 : 1);
      chk({nm, ".mem_ack_quiet"}, mem_ack_o, 0);
      chk({nm, ".if_data"}, if_data_o, exp_if_data);
      if_req_i = 1'b0;
    end
    @(negedge clk);
    chk({nm, ".ack_pulse"}, {if_ack_o, mem_ack_o}, 0);
  endtask

  // MEM is granted before IF whenever both are present, so its transaction is served first.
  task automatic do_vec(input string nm, input vec_t v);
    if_req_i    = v.use_if;
    if_addr_i   = v.iaddr;
    mem_re_i    = v.use_mem ? v.re : 2'b00;
    mem_we_i    = v.use_mem ? v.we : 2'b00;
    mem_rsign_i = v.sign;
    mem_addr_i  = v.maddr;
    mem_wdata_i = v.wdata;
    if (v.use_mem)
      serve({nm, ".m"}, 1'b1, v.exp_re, v.exp_we, v.sign, v.maddr, v.wdata, v.rd_mem, v.dly, 0);
    if (v.use_if)
      serve({nm, ".i"}, 1'b0, 2'b11, 2'b00, 1'b0, v.iaddr, 32'h0, v.rd_if, v.dly, 0);
  endtask

  // Reference: a store wins over a simultaneous load and is issued with no read size.
  function automatic vec_t rand_vec();
    vec_t v;
    int pat;
    pat       = $urandom_range(0, 2);
    v.use_if  = (pat != 1);
    v.use_mem = (pat != 0);
    v.re      = 2'($urandom_range(0, 3));
    v.we      = 2'($urandom_range(0, 3));
    if (v.re == 2'b00 && v.we == 2'b00) v.re = 2'b01;
    v.sign    = 1'($urandom_range(0, 1));
    v.iaddr   = $urandom & 32'hFFFF_FFFC;
    v.maddr   = $urandom;
    v.wdata   = $urandom;
    v.rd_if   = $urandom;
    v.rd_mem  = $urandom;
    v.dly     = $urandom_range(0, 6);
    v.exp_we  = v.we;
    v.exp_re  = (v.we != 2'b00) ? 2'b00 : v.re;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 0, 2'b00, 2'b00, 0, 32'h100, 32'h0,  32'h0,        32'hDEADBEEF, 32'h0,
                7, 2'b00, 2'b00};
    vecs[1] = '{1, 1, 2'b01, 2'b00, 1, 32'h200, 32'h20, 32'h0,        32'hCAFEF00D, 32'hA5,
                2, 2'b01, 2'b00};
    vecs[2] = '{0, 1, 2'b10, 2'b11, 0, 32'h0,   32'h40, 32'h12345678, 32'h0, 32'hFFFFFFFF,
                3, 2'b00, 2'b11};
    vecs[3] = '{1, 1, 2'b01, 2'b10, 1, 32'h204, 32'h42, 32'h0000BEEF, 32'h11112222, 32'h5A5A,
                0, 2'b00, 2'b10};
    vecs[4] = '{0, 1, 2'b10, 2'b00, 1, 32'h0,   32'h46, 32'h0,        32'h0, 32'h0000F00F,
                1, 2'b10, 2'b00};
    vecs[5] = '{1, 1, 2'b11, 2'b01, 0, 32'h208, 32'h47, 32'h000000C3, 32'h33334444, 32'h0,
                4, 2'b00, 2'b01};

    rst = 1'b0; rdy = 1'b1;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    mem_re_i = 0; mem_we_i = 0; mem_rsign_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    mc_busy_i = 0; mc_done_i = 0; mc_data_i = 0;
    repeat (3) @(negedge clk);
    chk("reset.acks", {if_ack_o, mem_ack_o}, 0);
    chk("reset.cmd", {mc_re_o, mc_we_o, mc_rsign_o}, 0);
    chk("reset.addr", mc_addr_o, 0);
    chk("reset.data", if_data_o | mem_rdata_o | mc_wdata_o, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

    // Controller busy holds off the grant.
    mc_busy_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h300;
    repeat (3) @(negedge clk);
    chk("busy.no_issue", {mc_re_o, mc_we_o}, 0);
    mc_busy_i = 1'b0;
    serve("busy", 1'b0, 2'b11, 2'b00, 1'b0, 32'h300, 32'h0, 32'h13579BDF, 2, 0);

    // Flush in IDLE blocks the fetch grant for that cycle.
    if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 32'h310;
    @(negedge clk);
    chk("idle_flush.no_issue", {mc_re_o, mc_we_o}, 0);
    if_flush_i = 1'b0;
    serve("idle_flush", 1'b0, 2'b11, 2'b00, 1'b0, 32'h310, 32'h0, 32'h2468ACE0, 1, 0);

    // Flush in WAIT drops the ack; the following fetch completes normally.
    if_req_i = 1'b1; if_addr_i = 32'h400;
    serve("wait_flush", 1'b0, 2'b11, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0BADBAD0, 2, 1);
    if_req_i = 1'b1; if_addr_i = 32'h404;
    serve("after_flush", 1'b0, 2'b11, 2'b00, 1'b0, 32'h404, 32'h0, 32'h76543210, 2, 0);

    // rdy low freezes ISSUE and stretches the ack pulse.
    if_req_i = 1'b1; if_addr_i = 32'h500;
    @(negedge clk);
    chk("rdy.issue", mc_re_o, 2'b11);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rdy.issue_frozen", mc_re_o, 2'b11);
    rdy = 1'b1;
    @(negedge clk);
    chk("rdy.wait", mc_re_o, 2'b00);
    mc_done_i = 1'b1; mc_data_i = 32'h600DF00D;
    @(negedge clk);
    mc_done_i = 1'b0; mc_data_i = 32'h0;
    exp_if_data = 32'h600DF00D;
    chk("rdy.ack", if_ack_o, 1);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rdy.ack_extended", if_ack_o, 1);
    chk("rdy.data", if_data_o, exp_if_data);
    rdy = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    chk("rdy.ack_cleared", if_ack_o, 0);

    // Reset in WAIT clears everything at once; a stale done afterwards does nothing.
    if_req_i = 1'b1; if_addr_i = 32'h700;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait.addr", mc_addr_o, 0);
    chk("rst_wait.data", if_data_o | mem_rdata_o, 0);
    exp_if_data = 32'h0; exp_mem_rdata = 32'h0;
    if_req_i = 1'b0; mc_done_i = 1'b1; mc_data_i = 32'hEEEEEEEE;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wait.stale_done", {if_ack_o, mem_ack_o, mc_re_o, mc_we_o}, 0);
    chk("rst_wait.data_after", if_data_o, 0);
    mc_done_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h704;
    serve("after_rst", 1'b0, 2'b11, 2'b00, 1'b0, 32'h704, 32'h0, 32'h31415926, 1, 0);

    for (int i = 0; i < 30; i++) do_vec($sformatf("rnd%0d", i), rand_vec());

`ifdef ARB_FAIRNESS_EN
    begin
      int starve;
      int n;
      bit exp_if, got_if;
      starve = 0;
      mem_re_i = 2'b01; mem_we_i = 2'b00; mem_addr_i = 32'h80; if_req_i = 1'b1;
      if_addr_i = 32'h900;
      for (int k = 0; k < 10; k++) begin
        exp_if = (starve >= int'(LIMIT));
        starve = exp_if ? 0 : starve + 1;
        @(negedge clk);
        n = 0;
        while (mc_re_o == 2'b00 && mc_we_o == 2'b00 && n < 20) begin
          @(negedge clk);
          n++;
        end
        got_if = (mc_re_o == 2'b11);
        chk($sformatf("fair%0d.owner_is_if", k), got_if, exp_if);
        @(negedge clk);
        mc_done_i = 1'b1; mc_data_i = $urandom;
        @(negedge clk);
        mc_done_i = 1'b0;
        if (k == 9) begin
          mem_re_i = 2'b00; if_req_i = 1'b0;
        end
        @(negedge clk);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
